// File: rtl/conv_accel_chip.sv
// conv_accel_chip: streaming 2-D convolution engine for one output feature map.
//
// Each output (y, x, ch) accumulates KERNEL_SIZE x INPUT_NB_CHANNELS beats,
// where every beat is a 3-lane signed dot product of an activation row and a
// weight row. When an output completes, the saturated result is strobed on
// `out` and the full-precision sum is written to external memory.
//
// Ports:
//   clk, arst_n_in            clock (rising edge), async active-low reset
//   ext_mem_read_addr         read address, always 0
//   ext_mem_qout              read data (not consumed)
//   ext_mem_write_addr/din/en write port, one-cycle strobe per result
//   a_input0..2, a_valid/ready activation row stream
//   b_input0..2, b_valid/ready weight row stream
//   out, output_valid         saturated result and its one-cycle strobe
//   output_x/y/ch             coordinates of the result on `out`
//   start, running            layer start request and busy flag
//   state_dbg                 current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a beat is consumed on a rising edge only when a_valid, b_valid,
// a_ready and b_ready are all high at that edge; a lone valid consumes nothing.
// There is no output back-pressure.
module conv_accel_chip #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int EXT_MEM_WIDTH      = ACCUMULATION_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  localparam int AW  = (EXT_MEM_HEIGHT > 1) ? $clog2(EXT_MEM_HEIGHT) : 1,
  localparam int XW  = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1,
  localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CW  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int IW  = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1,
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  output logic [AW-1:0]            ext_mem_read_addr,
  input  logic [EXT_MEM_WIDTH-1:0] ext_mem_qout,
  output logic [AW-1:0]            ext_mem_write_addr,
  output logic [EXT_MEM_WIDTH-1:0] ext_mem_din,
  output logic                     ext_mem_write_en,
  input  logic [IO_DATA_WIDTH-1:0] a_input0,
  input  logic [IO_DATA_WIDTH-1:0] a_input1,
  input  logic [IO_DATA_WIDTH-1:0] a_input2,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [IO_DATA_WIDTH-1:0] b_input0,
  input  logic [IO_DATA_WIDTH-1:0] b_input1,
  input  logic [IO_DATA_WIDTH-1:0] b_input2,
  input  logic                     b_valid,
  output logic                     b_ready,
  output logic [IO_DATA_WIDTH-1:0] out,
  output logic                     output_valid,
  output logic [XW-1:0]            output_x,
  output logic [YW-1:0]            output_y,
  output logic [CW-1:0]            output_ch,
  input  logic                     start,
  output logic                     running,
  output logic                     state_dbg
);

  localparam int IO  = IO_DATA_WIDTH;
  localparam int ACC = ACCUMULATION_WIDTH;
  localparam int PW  = 2 * IO_DATA_WIDTH;

  localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(INPUT_NB_CHANNELS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [XW-1:0] X_LAST = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_MAP_HEIGHT - 1);

  localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-IO+1){1'b0}}, {(IO-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-IO+1){1'b1}}, {(IO-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;

  logic [KW-1:0] ky_cnt;
  logic [IW-1:0] ci_cnt;
  logic [CW-1:0] ch_cnt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [AW-1:0] wr_ptr;
  logic          finish_q;   // final output of the layer is being presented
  logic signed [ACC-1:0] acc;

  logic signed [PW-1:0]  p0, p1, p2;
  logic signed [ACC-1:0] beat_sum, acc_next;
  logic [IO-1:0]         sat_val;
  logic                  fire, last_beat;
  logic                  unused_qout;

  assign unused_qout       = ^ext_mem_qout;
  assign ext_mem_read_addr = '0;

  // Ready is withheld during the cycle the layer's final result is shown, so
  // no stray beat is absorbed after the last output of the layer.
  assign a_ready   = (state == RUN) && !finish_q;
  assign b_ready   = a_ready;
  assign running   = (state == RUN);
  assign state_dbg = state;
  assign fire      = a_valid && b_valid && a_ready && b_ready;
  assign last_beat = (ky_cnt == K_LAST) && (ci_cnt == I_LAST);

  assign p0       = PW'($signed(a_input0)) * PW'($signed(b_input0));
  assign p1       = PW'($signed(a_input1)) * PW'($signed(b_input1));
  assign p2       = PW'($signed(a_input2)) * PW'($signed(b_input2));
  assign beat_sum = ACC'(p0) + ACC'(p1) + ACC'(p2);
  assign acc_next = acc + beat_sum;

  always_comb begin
    sat_val = acc_next[IO-1:0];
    if (acc_next > SAT_MAX) begin
      sat_val = {1'b0, {(IO-1){1'b1}}};
    end else if (acc_next < SAT_MIN) begin
      sat_val = {1'b1, {(IO-1){1'b0}}};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= IDLE;
    else            state <= state_next;
  end

  // FSM next-state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counters, accumulator, result and memory-write registers
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      ky_cnt             <= '0;
      ci_cnt             <= '0;
      ch_cnt             <= '0;
      x_cnt              <= '0;
      y_cnt              <= '0;
      wr_ptr             <= '0;
      finish_q           <= 1'b0;
      acc                <= '0;
      out                <= '0;
      output_valid       <= 1'b0;
      output_x           <= '0;
      output_y           <= '0;
      output_ch          <= '0;
      ext_mem_write_addr <= '0;
      ext_mem_din        <= '0;
      ext_mem_write_en   <= 1'b0;
    end else begin
      output_valid     <= 1'b0;
      ext_mem_write_en <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ky_cnt   <= '0;
          ci_cnt   <= '0;
          ch_cnt   <= '0;
          x_cnt    <= '0;
          y_cnt    <= '0;
          wr_ptr   <= '0;
          finish_q <= 1'b0;
          acc      <= '0;
        end
      end else if (finish_q) begin
        finish_q <= 1'b0;
      end else if (fire) begin
        if (last_beat) begin
          // Result registers load and the accumulator clears on the same edge,
          // so the next beat can begin the following output with no bubble.
          acc                <= '0;
          out                <= sat_val;
          output_valid       <= 1'b1;
          output_x           <= x_cnt;
          output_y           <= y_cnt;
          output_ch          <= ch_cnt;
          ext_mem_din        <= EXT_MEM_WIDTH'(acc_next);
          ext_mem_write_addr <= wr_ptr;
          ext_mem_write_en   <= 1'b1;
          ky_cnt             <= '0;
          ci_cnt             <= '0;
          // Outputs are produced in address order, so a running pointer
          // equals (y*W + x)*Cout + ch without a multiplier.
          wr_ptr             <= wr_ptr + AW'(1);
          if (ch_cnt == C_LAST) begin
            ch_cnt <= '0;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) begin
                y_cnt    <= '0;
                wr_ptr   <= '0;
                finish_q <= 1'b1;
              end else begin
                y_cnt <= y_cnt + YW'(1);
              end
            end else begin
              x_cnt <= x_cnt + XW'(1);
            end
          end else begin
            ch_cnt <= ch_cnt + CW'(1);
          end
        end else begin
          acc <= acc_next;
          if (ky_cnt == K_LAST) begin
            ky_cnt <= '0;
            ci_cnt <= ci_cnt + IW'(1);
          end else begin
            ky_cnt <= ky_cnt + KW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_accel_chip.sv
// Testbench for conv_accel_chip: small geometry (2x2 map, 2 in / 2 out
// channels, 3 kernel rows). A driver issues beats and feeds accepted ones to a
// behavioural model that pushes expected results into exp_q; a monitor pops
// and compares whenever the DUT strobes a result.
module tb_conv_accel_chip;

  localparam int IO    = 16;
  localparam int ACC   = 32;
  localparam int MEMH  = 64;
  localparam int W     = 2;
  localparam int H     = 2;
  localparam int CIN   = 2;
  localparam int COUT  = 2;
  localparam int K     = 3;
  localparam int AW    = 6;
  localparam int XW    = 1;
  localparam int YW    = 1;
  localparam int CW    = 1;
  localparam int BPO   = K * CIN;
  localparam int NOUT  = W * H * COUT;
  localparam int TOTAL = BPO * NOUT;

  // clock / reset
  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]  ext_mem_read_addr, ext_mem_write_addr;
  logic [ACC-1:0] ext_mem_qout, ext_mem_din;
  logic           ext_mem_write_en;
  logic [IO-1:0]  a_input0, a_input1, a_input2, b_input0, b_input1, b_input2;
  logic           a_valid, a_ready, b_valid, b_ready;
  logic [IO-1:0]  out;
  logic           output_valid;
  logic [XW-1:0]  output_x;
  logic [YW-1:0]  output_y;
  logic [CW-1:0]  output_ch;
  logic           start, running, state_dbg;

  conv_accel_chip #(
    .IO_DATA_WIDTH(IO), .ACCUMULATION_WIDTH(ACC), .EXT_MEM_HEIGHT(MEMH),
    .EXT_MEM_WIDTH(ACC), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .ext_mem_read_addr(ext_mem_read_addr), .ext_mem_qout(ext_mem_qout),
    .ext_mem_write_addr(ext_mem_write_addr), .ext_mem_din(ext_mem_din),
    .ext_mem_write_en(ext_mem_write_en),
    .a_input0(a_input0), .a_input1(a_input1), .a_input2(a_input2),
    .a_valid(a_valid), .a_ready(a_ready),
    .b_input0(b_input0), .b_input1(b_input1), .b_input2(b_input2),
    .b_valid(b_valid), .b_ready(b_ready),
    .out(out), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .start(start), .running(running), .state_dbg(state_dbg)
  );

  // scoreboard
  typedef struct packed {
    logic [ACC-1:0] din;
    logic [IO-1:0]  out;
    logic [AW-1:0]  addr;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [CW-1:0]  ch;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [IO-1:0] last_out = '0;

  // reference model state
  int m_sum;
  int m_beats;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One accepted beat: accumulate, and when an output completes derive its
  // coordinates from the output index (y outer, x, ch inner).
  task automatic model_beat(input int a0, input int a1, input int a2,
                            input int b0, input int b1, input int b2);
    int o, s, sv;
    exp_t e;
    m_sum = m_sum + a0 * b0 + a1 * b1 + a2 * b2;
    m_beats++;
    if (m_beats % BPO == 0) begin
      o = m_beats / BPO - 1;
      s = m_sum;
      if (s > 32767) sv = 32767;
      else if (s < -32768) sv = -32768;
      else sv = s;
      e.din  = ACC'(s);
      e.out  = IO'(sv);
      e.ch   = CW'(o % COUT);
      e.x    = XW'((o / COUT) % W);
      e.y    = YW'(o / (COUT * W));
      e.addr = AW'(((o / (COUT * W)) * W + (o / COUT) % W) * COUT + o % COUT);
      exp_q.push_back(e);
      m_sum = 0;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (output_valid || ext_mem_write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got x=%0d y=%0d ch=%0d din=%0d want none",
                 output_x, output_y, output_ch, $signed(ext_mem_din));
      end else begin
        e = exp_q.pop_front();
        chk("out", out, e.out);
        chk("din", ext_mem_din, e.din);
        chk("write_addr", ext_mem_write_addr, e.addr);
        chk("output_x", output_x, e.x);
        chk("output_y", output_y, e.y);
        chk("output_ch", output_ch, e.ch);
        chk("write_en", ext_mem_write_en, 1);
        chk("output_valid", output_valid, 1);
        last_out = e.out;
      end
    end
  end

  // driver
  task automatic gen_data(input int mode, output int a0, output int a1, output int a2,
                          output int b0, output int b1, output int b2);
    case (mode)
      0: begin a0 = 1; a1 = 1; a2 = 1; b0 = 1; b1 = 1; b2 = 1; end
      1: begin a0 = 200; a1 = 200; a2 = 200; b0 = 200; b1 = 200; b2 = 200; end
      2: begin a0 = -200; a1 = -200; a2 = -200; b0 = 200; b1 = 200; b2 = 200; end
      3: begin a0 = 3; a1 = -2; a2 = 5; b0 = 4; b1 = 7; b2 = -1; end
      default: begin
        a0 = int'($urandom_range(600)) - 300;
        a1 = int'($urandom_range(600)) - 300;
        a2 = int'($urandom_range(600)) - 300;
        b0 = int'($urandom_range(600)) - 300;
        b1 = int'($urandom_range(600)) - 300;
        b2 = int'($urandom_range(600)) - 300;
      end
    endcase
  endtask

  // gap: 0 both valids high, 1 a_valid toggling / b_valid held, 2 random.
  task automatic run_layer(input int mode, input int gap, input int limit, input bit pulse_start);
    int cyc;
    int a0, a1, a2, b0, b1, b2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_sum = 0;
    m_beats = 0;
    cyc = 0;
    while (m_beats < limit && cyc < 4000) begin
      gen_data(mode, a0, a1, a2, b0, b1, b2);
      a_input0 = IO'(a0); a_input1 = IO'(a1); a_input2 = IO'(a2);
      b_input0 = IO'(b0); b_input1 = IO'(b1); b_input2 = IO'(b2);
      case (gap)
        0:       begin a_valid = 1'b1; b_valid = 1'b1; end
        1:       begin a_valid = (cyc % 2 == 0); b_valid = 1'b1; end
        default: begin a_valid = 1'($urandom_range(1)); b_valid = 1'($urandom_range(1)); end
      endcase
      start = pulse_start && (cyc == 7);
      chk("a_ready", a_ready, 1);
      chk("b_ready", b_ready, 1);
      if (a_valid && b_valid && a_ready && b_ready)
        model_beat(a0, a1, a2, b0, b1, b2);
      @(negedge clk);
      cyc++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    start = 1'b0;
    chk("beat_budget", m_beats, limit);
    if (limit == TOTAL) begin
      chk("running_hold", running, 1);
      @(negedge clk);
      chk("running_drop", running, 0);
      chk("queue_empty", exp_q.size(), 0);
      @(negedge clk);
      chk("out_hold", out, last_out);
      chk("idle_ready", a_ready, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ext_mem_qout = '0;
    a_input0 = '0; a_input1 = '0; a_input2 = '0;
    b_input0 = '0; b_input1 = '0; b_input2 = '0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    start = 1'b1;
    arst_n_in = 1'b0;

    // reset held with start asserted
    repeat (3) @(negedge clk);
    chk("rst_running", running, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_output_valid", output_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_write_en", ext_mem_write_en, 0);
    chk("rst_din", ext_mem_din, 0);
    chk("rst_write_addr", ext_mem_write_addr, 0);
    chk("read_addr", ext_mem_read_addr, 0);
    start = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_running", running, 0);

    run_layer(0, 0, TOTAL, 1'b0);   // all ones: each result 18
    run_layer(0, 1, TOTAL, 1'b0);   // gapped a_valid
    run_layer(1, 0, TOTAL, 1'b0);   // positive saturation
    run_layer(2, 2, TOTAL, 1'b0);   // negative saturation, random valids
    run_layer(3, 0, TOTAL, 1'b1);   // mixed signs, start pulse while running
    run_layer(4, 2, TOTAL, 1'b0);   // random data and valids
    run_layer(4, 0, TOTAL, 1'b0);

    // reset in the middle of a layer: partial sum dropped, no write issued
    run_layer(4, 0, 15, 1'b0);
    arst_n_in = 1'b0;
    @(negedge clk);
    chk("midrst_running", running, 0);
    chk("midrst_out", out, 0);
    chk("midrst_din", ext_mem_din, 0);
    arst_n_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_queue", exp_q.size(), 0);
    chk("midrst_idle", running, 0);

    // fresh start must begin again at (0,0,0) with a clean accumulator
    run_layer(4, 2, TOTAL, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
